// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: DTCM wait handling with timeout, taken-branch
// flushes and load-use interlocks, plus stall/flush performance counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_valid,
  input  logic        dtcm_ready,
  output logic        dtcm_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        pc_sel,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  logic timeout_hit, release_c, mem_stall, load_use;

  assign timeout_hit = (state_reg == MEM_WAIT) && (wait_cnt_reg == WAIT_LAST);
  assign release_c   = (state_reg == MEM_WAIT) && (dtcm_ready || timeout_hit);
  assign mem_stall   = (state_reg == RUN) ? (mem_valid && !dtcm_ready) : !release_c;
  assign load_use    = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      // Held at zero in RUN so the count starts from zero on entry to MEM_WAIT.
      if (state_reg == RUN) begin
        wait_cnt_reg <= 8'd0;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
      if (stall_if) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (flush_ex) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (mem_valid && !dtcm_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (release_c) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    dtcm_req  = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    pc_sel    = 1'b0;
    mem_err   = 1'b0;
    if (!rst) begin
      dtcm_req = (state_reg == MEM_WAIT) ? 1'b1 : mem_valid;
      mem_err  = timeout_hit && !dtcm_ready;
      // Memory stall wins outright; the release cycle counts as unstalled.
      if (mem_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (ex_branch_taken) begin
        pc_sel   = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model queues expected
// outputs per cycle, a monitor process compares them on the falling edge.
module tb_pipe_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic        ex_branch_taken = 0, mem_valid = 0, dtcm_ready = 0;
  logic        dtcm_req, stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, pc_sel, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_valid(mem_valid), .dtcm_ready(dtcm_ready), .dtcm_req(dtcm_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .pc_sel(pc_sel), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [8:0]  ctrl;  // {req, s_if, s_id, s_ex, s_mem, f_id, f_ex, pc_sel, err}
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: stall episodes tracked by the cycle they began.
  int          cyc_n = 0;
  bit          waiting = 0;
  int          stall_begin = 0;
  logic [31:0] m_scnt = 0, m_fcnt = 0;

  task automatic step(input logic r, mv, rdy, br, emr, input logic [4:0] erd,
                      input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
    exp_t e;
    bit hold, err, req, hazard;
    bit s_if, s_id, s_ex, s_mem, f_id, f_ex, pcs;
    @(posedge clk);
    #1;
    rst = r; mem_valid = mv; dtcm_ready = rdy; ex_branch_taken = br;
    ex_mem_read = emr; ex_rd = erd; id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
    {hold, err, req, s_if, s_id, s_ex, s_mem, f_id, f_ex, pcs} = '0;
    e.cyc = cyc_n; e.scnt = m_scnt; e.fcnt = m_fcnt;
    if (r) begin
      waiting = 0;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (!waiting) begin
        req = mv;
        if (mv && !rdy) begin
          hold = 1; waiting = 1; stall_begin = cyc_n;
        end
      end else begin
        req = 1;
        if (rdy) waiting = 0;
        else if (cyc_n - stall_begin == T) begin waiting = 0; err = 1; end
        else hold = 1;
      end
      hazard = emr && (erd != 0) && ((u1 && r1 == erd) || (u2 && r2 == erd));
      if (hold) {s_if, s_id, s_ex, s_mem} = 4'b1111;
      else if (br) {pcs, f_id, f_ex} = 3'b111;
      else if (hazard) {s_if, s_id, f_ex} = 3'b111;
      if (s_if) m_scnt = m_scnt + 1;
      if (f_ex) m_fcnt = m_fcnt + 1;
    end
    e.ctrl = {req, s_if, s_id, s_ex, s_mem, f_id, f_ex, pcs, err};
    exp_q.push_back(e);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  // Monitor: outputs are presented every cycle, so one queued entry per falling edge.
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {dtcm_req, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, pc_sel, mem_err};
        n_cmp++;
        if (got !== e.ctrl) begin
          n_err++;
          $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctrl);
        end
        n_cmp++;
        if (stall_cnt !== e.scnt) begin
          n_err++;
          $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.cyc, stall_cnt, e.scnt);
        end
        n_cmp++;
        if (flush_cnt !== e.fcnt) begin
          n_err++;
          $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", e.cyc, flush_cnt, e.fcnt);
        end
        $display("cyc=%0d ctrl=%b scnt=%0d fcnt=%0d", e.cyc, got, stall_cnt, flush_cnt);
      end
    end
  end

  initial begin
    @(posedge clk);
    step(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    step(1, 1, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    idle(1);
    // load-use on rs1
    step(0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    idle(1);
    // x0 is never a hazard
    step(0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
    idle(1);
    // three wait cycles, then ready
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    step(0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(1);
    // timeout
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(1);
    // branch + load-use held behind a memory stall
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 5'd7, 0, 5'd0, 1, 5'd7);
    step(0, 1, 1, 1, 1, 5'd7, 0, 5'd0, 1, 5'd7);
    idle(1);
    // ready exactly at the timeout cycle is a normal release
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    step(0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    // reset during MEM_WAIT
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    step(1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    step(1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(2);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) == 0), $urandom_range(1), ($urandom_range(9) < 4),
           ($urandom_range(4) == 0), $urandom_range(1), 5'($urandom_range(3)),
           $urandom_range(1), 5'($urandom_range(3)), $urandom_range(1), 5'($urandom_range(3)));
    end
    idle(1);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
